// File: rtl/id_ex_stage.sv
// Register-read stage of the pipelined LEGv8 core. It decodes the source fields, resolves
// operands (XZR rule, write-back bypass), holds the ID/EX register and inserts load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [63:0]       in_pc,
  output logic              in_ready,
  input  logic              stall_in,
  input  logic              flush,
  output logic [ADDR_W-1:0] rreg1,
  output logic [ADDR_W-1:0] rreg2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              out_valid,
  output logic [63:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic              out_memread
);

  localparam logic [10:0]       OP_LDUR  = 11'h7C2;
  localparam logic [10:0]       OP_STUR  = 11'h7C0;
  localparam logic [7:0]        OP_CBZ   = 8'hB4;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [10:0]       opcode;
  logic              use_rt;
  logic              is_load;
  logic              hazard;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign opcode  = in_instr[31:21];
  // Stores and CBZ read their data/test register from the Rt field instead of Rm.
  assign use_rt  = (opcode == OP_STUR) || (in_instr[31:24] == OP_CBZ);
  assign is_load = (opcode == OP_LDUR);
  assign rreg1   = ADDR_W'(in_instr[9:5]);
  assign rreg2   = use_rt ? ADDR_W'(in_instr[4:0]) : ADDR_W'(in_instr[20:16]);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    op1 = rdata1;
    if (rreg1 == ZERO_IDX)
      op1 = '0;
    else if (wb_regwrite && (wb_wreg == rreg1))
      op1 = wb_wdata;
  end

  always_comb begin
    op2 = rdata2;
    if (rreg2 == ZERO_IDX)
      op2 = '0;
    else if (wb_regwrite && (wb_wreg == rreg2))
      op2 = wb_wdata;
  end

  // Conservative: compares both read ports whether or not the instruction really uses them.
  assign hazard = in_valid && out_valid && out_memread && (out_rd != ZERO_IDX)
               && ((out_rd == rreg1) || (out_rd == rreg2));

  assign in_ready = !stall_in && !hazard && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_memread <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rd      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_memread <= 1'b0;
    end else if (stall_in) begin
      // Hold everything; a write-back during the stall is left to downstream forwarding.
    end else if (hazard) begin
      out_valid   <= 1'b0;
      out_memread <= 1'b0;
    end else begin
      out_valid   <= in_valid;
      out_memread <= in_valid && is_load;
      out_pc      <= in_pc;
      out_instr   <= in_instr;
      out_rd      <= ADDR_W'(in_instr[4:0]);
      out_op1     <= op1;
      out_op2     <= op2;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, load-use/stall/flush/reset
// sequences, then randomized traffic against a behavioural model of the ID/EX entry.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        in_ready;
  logic        stall_in;
  logic        flush;
  logic [4:0]  rreg1, rreg2;
  logic [63:0] rdata1, rdata2;
  logic        wb_regwrite;
  logic [4:0]  wb_wreg;
  logic [63:0] wb_wdata;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rd;
  logic [63:0] out_op1, out_op2;
  logic        out_memread;

  logic [63:0] rf [32];
  assign rdata1 = rf[rreg1];
  assign rdata2 = rf[rreg2];

  id_ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .stall_in(stall_in), .flush(flush), .rreg1(rreg1), .rreg2(rreg2),
    .rdata1(rdata1), .rdata2(rdata2), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_rd(out_rd), .out_op1(out_op1), .out_op2(out_op2), .out_memread(out_memread)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_add(input int rd, input int rn, input int rm);
    return {11'h458, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] enc_ldur(input int rt, input int rn, input int imm);
    return {11'h7C2, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_stur(input int rt, input int rn, input int imm);
    return {11'h7C0, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_cbz(input int rt, input int imm);
    return {8'hB4, 19'(imm), 5'(rt)};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic st, input logic fl, input logic wr,
                       input logic [4:0] wreg, input logic [63:0] wdata);
    in_valid = v; in_instr = ins; in_pc = pc; stall_in = st; flush = fl;
    wb_regwrite = wr; wb_wreg = wreg; wb_wdata = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_memread"}, out_memread, 1'b0);
    check({tag, "_pc"}, out_pc, 64'd0);
    check({tag, "_instr"}, out_instr, 32'd0);
    check({tag, "_rd"}, out_rd, 5'd0);
    check({tag, "_op1"}, out_op1, 64'd0);
    check({tag, "_op2"}, out_op2, 64'd0);
  endtask

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] instr;
    logic        wr;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic [4:0]  e_r1, e_r2, e_rd;
    logic [63:0] e_op1, e_op2;
    logic        e_mr;
  } vec_t;

  // Behavioural view of the ID/EX entry for the randomized phase.
  typedef struct {
    logic        valid;
    logic        mr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] op1, op2;
  } entry_t;

  function automatic logic [4:0] src2_of(input logic [31:0] ins);
    if (ins[31:21] == 11'h7C0 || ins[31:24] == 8'hB4) return ins[4:0];
    return ins[20:16];
  endfunction

  function automatic logic [63:0] read_val(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (wb_regwrite && wb_wreg == idx) return wb_wdata;
    return rf[idx];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t   vecs [11];
  entry_t m, nm;
  logic [4:0] pool [5];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'(i);
    reset = 1'b1;
    idle();
    #7;
    check_cleared("reset_init");
    @(negedge clk);
    reset = 1'b0;
    tick();

    vecs[0]  = '{"add_basic",   1'b1, enc_add(3, 1, 2),   1'b0, 5'd0,  64'd0,     5'd1,  5'd2,  5'd3,  64'd1,     64'd2,     1'b0};
    vecs[1]  = '{"add_bypass",  1'b1, enc_add(3, 1, 2),   1'b1, 5'd2,  64'hDEAD,  5'd1,  5'd2,  5'd3,  64'd1,     64'hDEAD,  1'b0};
    vecs[2]  = '{"add_xzr_wb",  1'b1, enc_add(3, 1, 31),  1'b1, 5'd31, 64'hDEAD,  5'd1,  5'd31, 5'd3,  64'd1,     64'd0,     1'b0};
    vecs[3]  = '{"add_xzr_rn",  1'b1, enc_add(4, 31, 5),  1'b1, 5'd31, 64'hBEEF,  5'd31, 5'd5,  5'd4,  64'd0,     64'd5,     1'b0};
    vecs[4]  = '{"add_no_wr",   1'b1, enc_add(3, 1, 2),   1'b0, 5'd1,  64'hBEEF,  5'd1,  5'd2,  5'd3,  64'd1,     64'd2,     1'b0};
    vecs[5]  = '{"byp_both",    1'b1, enc_add(8, 6, 6),   1'b1, 5'd6,  64'hCAFE,  5'd6,  5'd6,  5'd8,  64'hCAFE,  64'hCAFE,  1'b0};
    vecs[6]  = '{"stur",        1'b1, enc_stur(7, 1, 8),  1'b0, 5'd0,  64'd0,     5'd1,  5'd7,  5'd7,  64'd1,     64'd7,     1'b0};
    vecs[7]  = '{"cbz",         1'b1, enc_cbz(9, 12),     1'b0, 5'd0,  64'd0,     5'd12, 5'd9,  5'd9,  64'd12,    64'd9,     1'b0};
    vecs[8]  = '{"ldur",        1'b1, enc_ldur(5, 1, 0),  1'b0, 5'd0,  64'd0,     5'd1,  5'd0,  5'd5,  64'd1,     64'd0,     1'b1};
    vecs[9]  = '{"ldur_byp",    1'b1, enc_ldur(10, 1, 0), 1'b1, 5'd1,  64'h55,    5'd1,  5'd0,  5'd10, 64'h55,    64'd0,     1'b1};
    vecs[10] = '{"ldur_inval",  1'b0, enc_ldur(5, 1, 0),  1'b0, 5'd0,  64'd0,     5'd1,  5'd0,  5'd5,  64'd1,     64'd0,     1'b0};

    for (int i = 0; i < 11; i++) begin
      idle();
      tick();
      drive(vecs[i].v, vecs[i].instr, 64'h1000 + 64'(i * 4), 1'b0, 1'b0,
            vecs[i].wr, vecs[i].wreg, vecs[i].wdata);
      #1;
      check({vecs[i].name, "_rreg1"}, rreg1, vecs[i].e_r1);
      check({vecs[i].name, "_rreg2"}, rreg2, vecs[i].e_r2);
      check({vecs[i].name, "_ready"}, in_ready, 1'b1);
      tick();
      check({vecs[i].name, "_valid"}, out_valid, vecs[i].v);
      check({vecs[i].name, "_memread"}, out_memread, vecs[i].e_mr);
      if (vecs[i].v) begin
        check({vecs[i].name, "_pc"}, out_pc, 64'h1000 + 64'(i * 4));
        check({vecs[i].name, "_instr"}, out_instr, vecs[i].instr);
        check({vecs[i].name, "_rd"}, out_rd, vecs[i].e_rd);
        check({vecs[i].name, "_op1"}, out_op1, vecs[i].e_op1);
        check({vecs[i].name, "_op2"}, out_op2, vecs[i].e_op2);
      end
    end

    // Asynchronous reset in the middle of a cycle with a valid entry latched.
    drive(1'b1, enc_add(3, 1, 2), 64'h2000, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    check("pre_reset_valid", out_valid, 1'b1);
    #3 reset = 1'b1;
    #1 check_cleared("reset_mid");
    #1 reset = 1'b0;
    idle();
    tick();

    // Load-use: one bubble, then the held ADD is captured.
    drive(1'b1, enc_ldur(5, 1, 0), 64'h200, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    check("lu_ld_memread", out_memread, 1'b1);
    drive(1'b1, enc_add(6, 5, 2), 64'h204, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    #1 check("lu_ready_low", in_ready, 1'b0);
    tick();
    check("lu_bubble_valid", out_valid, 1'b0);
    check("lu_bubble_memread", out_memread, 1'b0);
    check("lu_ready_back", in_ready, 1'b1);
    tick();
    check("lu_add_valid", out_valid, 1'b1);
    check("lu_add_rd", out_rd, 5'd6);
    check("lu_add_pc", out_pc, 64'h204);
    check("lu_add_op1", out_op1, 64'd5);

    // Load to XZR never creates a hazard.
    drive(1'b1, enc_ldur(31, 1, 0), 64'h208, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    drive(1'b1, enc_add(6, 31, 2), 64'h20C, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    #1 check("xzr_ld_ready", in_ready, 1'b1);
    tick();
    check("xzr_ld_valid", out_valid, 1'b1);
    check("xzr_ld_pc", out_pc, 64'h20C);
    check("xzr_ld_op1", out_op1, 64'd0);

    // Stall for three cycles (with a write-back to a latched source), then flush.
    drive(1'b1, enc_add(3, 1, 2), 64'h300, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, enc_add(10 + k, 4, 5), 64'h304, 1'b1, 1'b0, 1'b1, 5'd1, 64'hBAD);
      #1 check("stall_ready", in_ready, 1'b0);
      tick();
      check("stall_valid", out_valid, 1'b1);
      check("stall_pc", out_pc, 64'h300);
      check("stall_rd", out_rd, 5'd3);
      check("stall_op1", out_op1, 64'd1);
      check("stall_op2", out_op2, 64'd2);
    end
    drive(1'b1, enc_add(12, 4, 5), 64'h308, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
    #1 check("flush_ready", in_ready, 1'b0);
    tick();
    check("flush_valid", out_valid, 1'b0);
    check("flush_memread", out_memread, 1'b0);

    // Reset while a load-use hazard is pending: nothing retained, no bubble afterwards.
    drive(1'b1, enc_ldur(5, 1, 0), 64'h400, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    drive(1'b1, enc_add(6, 5, 2), 64'h404, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    #1 reset = 1'b1;
    #1 check_cleared("reset_hazard");
    check("reset_hazard_ready", in_ready, 1'b1);
    #1 reset = 1'b0;
    tick();
    check("post_reset_valid", out_valid, 1'b1);
    check("post_reset_rd", out_rd, 5'd6);

    // Randomized traffic against the behavioural model.
    idle();
    reset = 1'b1;
    #2 reset = 1'b0;
    m = '{default: '0};
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    pool = '{5'd1, 5'd2, 5'd5, 5'd6, 5'd31};
    begin
      logic        held;
      logic [31:0] ins;
      logic [63:0] pc;
      logic        v;
      held = 1'b0;
      ins  = 32'd0;
      pc   = 64'h8000;
      v    = 1'b0;
      for (int c = 0; c < 600; c++) begin
        logic [4:0] r1, r2;
        logic       hz, rdy;
        if (!held) begin
          int k;
          logic [4:0] a, b, d;
          k = int'($urandom_range(0, 4));
          a = pool[$urandom_range(0, 4)];
          b = pool[$urandom_range(0, 4)];
          d = pool[$urandom_range(0, 4)];
          case (k)
            0: ins = enc_add(int'(d), int'(a), int'(b));
            1: ins = enc_ldur(int'(d), int'(a), int'($urandom_range(0, 511)));
            2: ins = enc_stur(int'(d), int'(a), int'($urandom_range(0, 511)));
            3: ins = enc_cbz(int'(d), int'($urandom_range(0, 524287)));
            default: ins = $urandom;
          endcase
          pc = pc + 64'd4;
          v  = ($urandom_range(0, 4) != 0);
        end
        if ($urandom_range(0, 15) == 0) rf[$urandom_range(0, 31)] = {$urandom, $urandom};
        drive(v, ins, pc, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 1) == 1, pool[$urandom_range(0, 4)], {$urandom, $urandom});
        #1;
        r1  = ins[9:5];
        r2  = src2_of(ins);
        hz  = v && m.valid && m.mr && (m.rd != 5'd31) && (m.rd == r1 || m.rd == r2);
        rdy = !stall_in && !hz && !flush;
        check("rnd_rreg1", rreg1, r1);
        check("rnd_rreg2", rreg2, r2);
        check("rnd_ready", in_ready, rdy);
        nm = m;
        if (flush || (!stall_in && hz)) begin
          nm.valid = 1'b0;
          nm.mr    = 1'b0;
        end else if (!stall_in) begin
          nm.valid = v;
          nm.mr    = v && (ins[31:21] == 11'h7C2);
          nm.pc    = pc;
          nm.instr = ins;
          nm.rd    = ins[4:0];
          nm.op1   = read_val(r1);
          nm.op2   = read_val(r2);
        end
        held = v && !rdy;
        tick();
        m = nm;
        check("rnd_valid", out_valid, m.valid);
        check("rnd_memread", out_memread, m.mr);
        if (m.valid) begin
          check("rnd_pc", out_pc, m.pc);
          check("rnd_instr", out_instr, m.instr);
          check("rnd_rd", out_rd, m.rd);
          check("rnd_op1", out_op1, m.op1);
          check("rnd_op2", out_op2, m.op2);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
